// File: rtl/ddr_cmd_arbiter.sv
// ddr_cmd_arbiter: shares the DDR user-command port between the read streamer, the
// host write path and controller auto-refresh. It grants one owner at a time, asks
// owners to suspend for refresh or when the other requester is starving, and muxes
// CMD/address/burst_done onto the core port. All logic runs on the falling edge of
// CLK_in to match the DDR user-side timing.
module ddr_cmd_arbiter #(
  parameter int MAX_HOLD  = 64,
  parameter int DRAIN_MAX = 15
) (
  input  logic        CLK_in,
  input  logic        RESET_in,
  input  logic        Init_done,
  input  logic        ar_req,
  input  logic        ar_done,
  input  logic        CMD_ACK_in,
  input  logic        RD_REQ_in,
  input  logic [2:0]  RD_CMD_in,
  input  logic [25:0] RD_ADDR_in,
  input  logic        RD_BURST_DONE_in,
  input  logic        WR_REQ_in,
  input  logic [2:0]  WR_CMD_in,
  input  logic [25:0] WR_ADDR_in,
  input  logic        WR_BURST_DONE_in,
  output logic        RD_GNT_out,
  output logic        WR_GNT_out,
  output logic        RD_HOLD_out,
  output logic        WR_HOLD_out,
  output logic [2:0]  CMD_out,
  output logic [25:0] Addr_out,
  output logic        Burst_done_out,
  output logic        ERR_out
);

  localparam int DCW = $clog2(DRAIN_MAX + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DRAIN, S_REFRESH, S_ERROR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_RD, OWN_WR} owner_t;

  state_t         state_q, state_d;
  logic [7:0]     wait_q, wait_d;      // cycles the non-owner has been waiting
  logic [DCW-1:0] drain_q, drain_d;    // cycles spent in DRAIN with CMD_ACK still high
  owner_t         prev_q, prev_d;      // owner that released into DRAIN
  logic           held_q, held_d;      // that owner was released under HOLD
  owner_t         fair_q, fair_d;      // one-shot tie-break winner for the next IDLE grant
  logic [2:0]     cmd_q, cmd_d;
  logic [25:0]    addr_q, addr_d;
  logic           bd_q, bd_d;

  logic wait_full;
  logic rd_hold_own, wr_hold_own;

  assign wait_full   = (wait_q >= 8'(MAX_HOLD));
  assign rd_hold_own = (state_q == S_RD) && (ar_req || wait_full);
  assign wr_hold_own = (state_q == S_WR) && (ar_req || wait_full);

  // Next-state, counters and the registered command mux
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    drain_d = drain_q;
    prev_d  = prev_q;
    held_d  = held_q;
    fair_d  = fair_q;
    cmd_d   = 3'b000;
    addr_d  = addr_q;
    bd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_d = 8'd0;
        if (Init_done) begin
          if (ar_req) begin
            state_d = S_REFRESH;
          end else if (fair_q == OWN_WR && WR_REQ_in) begin
            state_d = S_WR;
            fair_d  = OWN_NONE;
          end else if (RD_REQ_in) begin
            state_d = S_RD;
            fair_d  = OWN_NONE;
          end else if (WR_REQ_in) begin
            state_d = S_WR;
            fair_d  = OWN_NONE;
          end
        end
      end
      S_RD: begin
        if (!RD_REQ_in || (rd_hold_own && RD_CMD_in == 3'b000)) begin
          state_d = S_DRAIN;
          drain_d = '0;
          wait_d  = 8'd0;
          prev_d  = OWN_RD;
          held_d  = rd_hold_own;
          // A release forced by starvation hands the next tie to the waiter
          fair_d  = (wait_full && !ar_req) ? OWN_WR : OWN_NONE;
        end else begin
          cmd_d  = RD_CMD_in;
          addr_d = RD_ADDR_in;
          bd_d   = RD_BURST_DONE_in;
          if (WR_REQ_in && wait_q != 8'hFF) wait_d = wait_q + 8'd1;
        end
      end
      S_WR: begin
        if (!WR_REQ_in || (wr_hold_own && WR_CMD_in == 3'b000)) begin
          state_d = S_DRAIN;
          drain_d = '0;
          wait_d  = 8'd0;
          prev_d  = OWN_WR;
          held_d  = wr_hold_own;
          fair_d  = (wait_full && !ar_req) ? OWN_RD : OWN_NONE;
        end else begin
          cmd_d  = WR_CMD_in;
          addr_d = WR_ADDR_in;
          bd_d   = WR_BURST_DONE_in;
          if (RD_REQ_in && wait_q != 8'hFF) wait_d = wait_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (!CMD_ACK_in) begin
          if (ar_req) begin
            state_d = S_REFRESH;
            held_d  = 1'b1;
            // Owner suspended by refresh regains the port first, unless a
            // starvation claim is already pending
            if (fair_q == OWN_NONE) fair_d = prev_q;
          end else begin
            state_d = S_IDLE;
            prev_d  = OWN_NONE;
            held_d  = 1'b0;
          end
        end else if (drain_q >= DCW'(DRAIN_MAX)) begin
          state_d = S_ERROR;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      S_REFRESH: begin
        if (ar_done) begin
          state_d = S_IDLE;
          prev_d  = OWN_NONE;
          held_d  = 1'b0;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  // State and output registers; reset aborts immediately, mid-burst or not
  always_ff @(negedge CLK_in or posedge RESET_in) begin
    if (RESET_in) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
      drain_q <= '0;
      prev_q  <= OWN_NONE;
      held_q  <= 1'b0;
      fair_q  <= OWN_NONE;
      cmd_q   <= 3'b000;
      addr_q  <= 26'd0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      prev_q  <= prev_d;
      held_q  <= held_d;
      fair_q  <= fair_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      bd_q    <= bd_d;
    end
  end

  // HOLD follows ar_req combinationally while owning, then persists through drain/refresh
  always_comb begin
    RD_HOLD_out = rd_hold_own;
    WR_HOLD_out = wr_hold_own;
    if ((state_q == S_DRAIN || state_q == S_REFRESH) && held_q) begin
      RD_HOLD_out = (prev_q == OWN_RD);
      WR_HOLD_out = (prev_q == OWN_WR);
    end
    if (state_q == S_ERROR) begin
      RD_HOLD_out = 1'b1;
      WR_HOLD_out = 1'b1;
    end
  end

  assign RD_GNT_out     = (state_q == S_RD);
  assign WR_GNT_out     = (state_q == S_WR);
  assign ERR_out        = (state_q == S_ERROR);
  assign CMD_out        = cmd_q;
  assign Addr_out       = addr_q;
  assign Burst_done_out = bd_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed bench for ddr_cmd_arbiter: a vector table for basic grant/mux
// behaviour, then hand-written sequences for refresh, starvation, drain timeout
// and asynchronous reset.
module tb_ddr_cmd_arbiter;

  logic        CLK_in, RESET_in, Init_done, ar_req, ar_done, CMD_ACK_in;
  logic        RD_REQ_in, RD_BURST_DONE_in, WR_REQ_in, WR_BURST_DONE_in;
  logic [2:0]  RD_CMD_in, WR_CMD_in;
  logic [25:0] RD_ADDR_in, WR_ADDR_in;
  logic        RD_GNT_out, WR_GNT_out, RD_HOLD_out, WR_HOLD_out, Burst_done_out, ERR_out;
  logic [2:0]  CMD_out;
  logic [25:0] Addr_out;

  int n_cmp = 0;
  int n_bad = 0;

  ddr_cmd_arbiter #(.MAX_HOLD(64), .DRAIN_MAX(15)) dut (
    .CLK_in(CLK_in), .RESET_in(RESET_in), .Init_done(Init_done),
    .ar_req(ar_req), .ar_done(ar_done), .CMD_ACK_in(CMD_ACK_in),
    .RD_REQ_in(RD_REQ_in), .RD_CMD_in(RD_CMD_in), .RD_ADDR_in(RD_ADDR_in),
    .RD_BURST_DONE_in(RD_BURST_DONE_in),
    .WR_REQ_in(WR_REQ_in), .WR_CMD_in(WR_CMD_in), .WR_ADDR_in(WR_ADDR_in),
    .WR_BURST_DONE_in(WR_BURST_DONE_in),
    .RD_GNT_out(RD_GNT_out), .WR_GNT_out(WR_GNT_out),
    .RD_HOLD_out(RD_HOLD_out), .WR_HOLD_out(WR_HOLD_out),
    .CMD_out(CMD_out), .Addr_out(Addr_out), .Burst_done_out(Burst_done_out),
    .ERR_out(ERR_out)
  );

  initial begin
    CLK_in = 1'b0;
    forever #5 CLK_in = ~CLK_in;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // {rd_gnt, wr_gnt, rd_hold, wr_hold, err, burst_done, cmd, addr}
  logic [34:0] obs;
  assign obs = {RD_GNT_out, WR_GNT_out, RD_HOLD_out, WR_HOLD_out, ERR_out,
                Burst_done_out, CMD_out, Addr_out};

  typedef struct {
    logic        init, ar, ack;
    logic        rreq; logic [2:0] rcmd; logic [25:0] raddr; logic rbd;
    logic        wreq; logic [2:0] wcmd; logic [25:0] waddr; logic wbd;
    logic [34:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic init, ar, ack,
                              input logic rreq, input logic [2:0] rcmd,
                              input logic [25:0] raddr, input logic rbd,
                              input logic wreq, input logic [2:0] wcmd,
                              input logic [25:0] waddr, input logic wbd,
                              input logic rg, wg, rh, wh, er, bd,
                              input logic [2:0] cmd, input logic [25:0] addr);
    vec_t v;
    v.init = init; v.ar = ar; v.ack = ack;
    v.rreq = rreq; v.rcmd = rcmd; v.raddr = raddr; v.rbd = rbd;
    v.wreq = wreq; v.wcmd = wcmd; v.waddr = waddr; v.wbd = wbd;
    v.exp = {rg, wg, rh, wh, er, bd, cmd, addr};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One DUT cycle: DUT acts on the falling edge, bench drives/samples at the rising edge
  task automatic tick();
    @(negedge CLK_in);
    @(posedge CLK_in);
  endtask

  task automatic clear_inputs();
    Init_done = 0; ar_req = 0; ar_done = 0; CMD_ACK_in = 0;
    RD_REQ_in = 0; RD_CMD_in = 3'b000; RD_ADDR_in = 26'd0; RD_BURST_DONE_in = 0;
    WR_REQ_in = 0; WR_CMD_in = 3'b000; WR_ADDR_in = 26'd0; WR_BURST_DONE_in = 0;
  endtask

  task automatic do_reset();
    RESET_in = 1;
    clear_inputs();
    tick();
    tick();
    RESET_in = 0;
  endtask

  localparam logic [25:0] AD_A = 26'h0000100;
  localparam logic [25:0] AD_B = 26'h0000104;
  localparam logic [25:0] AD_W = 26'h0001000;

  initial begin
    RESET_in = 1;
    clear_inputs();

    // Init held low blocks grants; RD beats WR on a tie; non-owner inputs ignored
    vecs[0]  = mk(0,0,0, 1,3'b110,AD_A,0, 0,3'b100,AD_W,0, 0,0,0,0,0,0, 3'b000, 26'd0);
    vecs[1]  = mk(0,0,0, 1,3'b110,AD_A,0, 0,3'b100,AD_W,0, 0,0,0,0,0,0, 3'b000, 26'd0);
    vecs[2]  = mk(1,0,0, 1,3'b110,AD_A,0, 1,3'b100,AD_W,0, 1,0,0,0,0,0, 3'b000, 26'd0);
    vecs[3]  = mk(1,0,0, 1,3'b110,AD_A,1, 1,3'b100,AD_W,0, 1,0,0,0,0,1, 3'b110, AD_A);
    vecs[4]  = mk(1,0,0, 1,3'b110,AD_B,0, 1,3'b100,AD_W,1, 1,0,0,0,0,0, 3'b110, AD_B);
    vecs[5]  = mk(1,0,0, 0,3'b110,AD_B,0, 1,3'b100,AD_W,0, 0,0,0,0,0,0, 3'b000, AD_B);
    vecs[6]  = mk(1,0,0, 0,3'b000,AD_B,0, 1,3'b100,AD_W,0, 0,0,0,0,0,0, 3'b000, AD_B);
    vecs[7]  = mk(1,0,0, 0,3'b000,AD_B,0, 1,3'b100,AD_W,0, 0,1,0,0,0,0, 3'b000, AD_B);
    vecs[8]  = mk(1,0,0, 0,3'b000,AD_B,0, 1,3'b100,AD_W,1, 0,1,0,0,0,1, 3'b100, AD_W);
    vecs[9]  = mk(1,0,0, 0,3'b000,AD_B,0, 0,3'b100,AD_W,0, 0,0,0,0,0,0, 3'b000, AD_W);
    vecs[10] = mk(1,0,0, 0,3'b000,AD_B,0, 0,3'b000,AD_W,0, 0,0,0,0,0,0, 3'b000, AD_W);

    tick();
    tick();
    check("reset_state", 64'(obs), 64'd0);
    RESET_in = 0;

    for (int i = 0; i < 11; i++) begin
      Init_done = vecs[i].init; ar_req = vecs[i].ar; CMD_ACK_in = vecs[i].ack;
      RD_REQ_in = vecs[i].rreq; RD_CMD_in = vecs[i].rcmd;
      RD_ADDR_in = vecs[i].raddr; RD_BURST_DONE_in = vecs[i].rbd;
      WR_REQ_in = vecs[i].wreq; WR_CMD_in = vecs[i].wcmd;
      WR_ADDR_in = vecs[i].waddr; WR_BURST_DONE_in = vecs[i].wbd;
      tick();
      check($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].exp));
      $display("vec %0d: obs=%09h exp=%09h", i, obs, vecs[i].exp);
    end

    // Refresh interrupts a read owner, then the write owner; fairness after refresh
    do_reset();
    Init_done = 1; RD_REQ_in = 1; RD_CMD_in = 3'b110; RD_ADDR_in = 26'h0000200;
    tick();
    check("ref_rd_gnt", 64'(RD_GNT_out), 64'd1);
    tick();
    check("ref_rd_cmd", 64'(CMD_out), 64'h6);
    ar_done = 1;
    tick();
    check("ref_ardone_ignored", 64'({RD_GNT_out, RD_HOLD_out}), 64'b10);
    ar_done = 0;
    ar_req = 1;
    #1;
    check("ref_rd_hold_same_cycle", 64'({RD_GNT_out, RD_HOLD_out}), 64'b11);
    tick();
    check("ref_rd_held_busy", 64'({RD_GNT_out, RD_HOLD_out, CMD_out}), 64'b11_110);
    RD_CMD_in = 3'b000; CMD_ACK_in = 1;
    tick();
    check("ref_rd_drain", 64'({RD_GNT_out, RD_HOLD_out, CMD_out}), 64'b01_000);
    tick();
    CMD_ACK_in = 0; WR_REQ_in = 1;
    tick();
    check("ref_rd_refresh", 64'({RD_GNT_out, WR_GNT_out, RD_HOLD_out, WR_HOLD_out, CMD_out}), 64'b0010_000);
    ar_req = 0; ar_done = 1;
    tick();
    check("ref_rd_exit_idle", 64'({RD_GNT_out, WR_GNT_out, RD_HOLD_out}), 64'b000);
    ar_done = 0;
    tick();
    check("ref_rd_regrant", 64'({RD_GNT_out, WR_GNT_out}), 64'b10);
    RD_REQ_in = 0;
    tick();
    tick();
    tick();
    check("ref_wr_gnt", 64'({RD_GNT_out, WR_GNT_out}), 64'b01);
    WR_CMD_in = 3'b100;
    ar_req = 1;
    #1;
    check("ref_wr_hold_same_cycle", 64'(WR_HOLD_out), 64'd1);
    WR_CMD_in = 3'b000; RD_REQ_in = 1;
    tick();
    tick();
    check("ref_wr_refresh_hold", 64'({RD_HOLD_out, WR_HOLD_out, RD_GNT_out, WR_GNT_out}), 64'b0100);
    ar_req = 0; ar_done = 1;
    tick();
    ar_done = 0;
    tick();
    check("ref_fair_wr_wins", 64'({RD_GNT_out, WR_GNT_out}), 64'b01);
    WR_REQ_in = 0;
    tick();
    tick();
    tick();
    check("ref_fair_one_shot", 64'({RD_GNT_out, WR_GNT_out}), 64'b10);

    // Starvation: WR waits MAX_HOLD cycles, RD gets HOLD, then WR takes the port
    do_reset();
    Init_done = 1; RD_REQ_in = 1; RD_CMD_in = 3'b110; RD_ADDR_in = 26'h0000040;
    tick();
    WR_REQ_in = 1; WR_CMD_in = 3'b100; WR_ADDR_in = AD_W;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) check("starve_no_hold_63", 64'(RD_HOLD_out), 64'd0);
    end
    check("starve_hold_64", 64'({RD_GNT_out, RD_HOLD_out}), 64'b11);
    RD_CMD_in = 3'b000;
    tick();
    check("starve_drain", 64'({RD_GNT_out, WR_GNT_out, RD_HOLD_out, CMD_out}), 64'b001_000);
    tick();
    tick();
    check("starve_wr_gnt", 64'({RD_GNT_out, WR_GNT_out}), 64'b01);
    tick();
    check("starve_wr_addr", 64'({CMD_out, Addr_out}), 64'({3'b100, AD_W}));

    // Drain timeout: 15 cycles of CMD_ACK is tolerated, the 16th is an error
    do_reset();
    Init_done = 1; RD_REQ_in = 1; RD_CMD_in = 3'b110; RD_ADDR_in = 26'h0000300;
    tick();
    tick();
    RD_REQ_in = 0; CMD_ACK_in = 1;
    tick();
    for (int k = 1; k <= 15; k++) tick();
    check("drain_15_no_err", 64'(ERR_out), 64'd0);
    tick();
    check("drain_16_err", 64'({ERR_out, RD_GNT_out, WR_GNT_out, RD_HOLD_out, WR_HOLD_out, CMD_out}),
          64'b10011_000);
    CMD_ACK_in = 0; RD_REQ_in = 1;
    tick();
    tick();
    check("err_sticky", 64'({ERR_out, RD_GNT_out, CMD_out}), 64'b10_000);
    RESET_in = 1;
    #1;
    check("err_async_reset", 64'(obs), 64'd0);
    tick();
    RESET_in = 0;
    clear_inputs();
    tick();
    check("err_after_reset", 64'(obs), 64'd0);

    // Reset mid-burst clears outputs without waiting for a clock edge
    do_reset();
    Init_done = 1; RD_REQ_in = 1; RD_CMD_in = 3'b110; RD_ADDR_in = 26'h0000500;
    RD_BURST_DONE_in = 1;
    tick();
    tick();
    check("midburst_active", 64'({RD_GNT_out, Burst_done_out, CMD_out}), 64'b11_110);
    RESET_in = 1;
    #1;
    check("midburst_async_clear", 64'(obs), 64'd0);
    @(negedge CLK_in);
    #1;
    check("midburst_held_in_reset", 64'(obs), 64'd0);
    @(posedge CLK_in);
    RESET_in = 0;
    clear_inputs();
    tick();
    check("midburst_no_spurious_bd", 64'(obs), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
